// File: rtl/alnsft_pipe.sv
// Purpose: per-lane right-shift alignment of LANES fractions, with a per-lane sticky bit and a tag sideband.
// Latency: STAGES cycles from input transfer to out_valid. Throughput is 1 transaction per cycle.
// Backpressure: out_ready stalls ripple combinationally back to in_ready, and empty stages (bubbles) collapse.
// Ports: clk; reset (synchronous, active-low); flush (drops everything in flight);
//        in_valid/in_ready/in_tag/acc/sft (lane k fraction at acc[k*W +: W], amount at sft[k*SW +: SW]);
//        out_valid/out_ready/out_tag/aln (lane k result at aln[k*(W+1) +: W+1]).
// Build option: ALNSFT_STICKY_EN. When defined, the LSB of each lane result is the OR of the bits
//               shifted out. When undefined, that LSB is tied to 0 and no OR tree is built.
module alnsft_pipe #(
  parameter int LANES  = 4,
  parameter int W      = 48,
  parameter int SW     = 6,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAGW-1:0]         in_tag,
  input  logic [LANES*W-1:0]      acc,
  input  logic [LANES*SW-1:0]     sft,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAGW-1:0]         out_tag,
  output logic [LANES*(W+1)-1:0]  aln
);

  localparam int AW = W + 1;

  // The full shift is resolved ahead of stage 1. Later stages only carry the result,
  // which keeps every stage identical and lets the handshake logic stay generic.
  // A shift count of W or more yields 0 from the shift, and the mask becomes all ones,
  // so the over-shift case needs no special handling.
  logic [LANES*AW-1:0] res;

  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      res[k*AW+1 +: W] = acc[k*W +: W] >> sft[k*SW +: SW];
`ifdef ALNSFT_STICKY_EN
      res[k*AW] = |(acc[k*W +: W] & ~({W{1'b1}} << sft[k*SW +: SW]));
`endif
    end
  end

  logic [STAGES-1:0]   vld;
  logic [STAGES-1:0]   rdy;   // stage is empty, or its content leaves this cycle
  logic [TAGW-1:0]     tag_q [STAGES];
  logic [LANES*AW-1:0] dat_q [STAGES];

  // Ready chain, walked from the output back to the input.
  always_comb begin
    logic nxt;
    rdy = '0;
    nxt = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      nxt    = !vld[i] || nxt;
      rdy[i] = nxt;
    end
  end

  assign in_ready = reset && rdy[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) vld[i] <= vld[i-1];
      end
    end
  end

  // Payload registers have no reset. They only change when a valid entry is loaded into them.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      if (rdy[0] && in_valid) begin
        tag_q[0] <= in_tag;
        dat_q[0] <= res;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i] && vld[i-1]) begin
          tag_q[i] <= tag_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign aln       = dat_q[STAGES-1];

endmodule

// File: tb/tb_alnsft_pipe.sv
// Purpose: randomized and directed stimulus for alnsft_pipe, checked against an arithmetic reference queue.
// Latency: checks that a lone transaction appears STAGES cycles after it is accepted.
// Backpressure: checks that in_ready stalls, held outputs stay stable, bubbles collapse, and flush/reset discard entries.
`timescale 1ns/1ps
module tb_alnsft_pipe;
  localparam int LANES = 4, W = 48, SW = 6, STAGES = 2, TAGW = 4, AW = W + 1;
`ifdef ALNSFT_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic                  clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic                  in_valid = 1'b0, out_ready = 1'b0;
  logic                  in_ready, out_valid;
  logic [TAGW-1:0]       in_tag = '0, out_tag;
  logic [LANES*W-1:0]    acc = '0;
  logic [LANES*SW-1:0]   sft = '0;
  logic [LANES*AW-1:0]   aln;

  alnsft_pipe #(.LANES(LANES), .W(W), .SW(SW), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .acc(acc), .sft(sft),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .aln(aln)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per lane, the quotient by 2^sft gives the upper bits, and a nonzero remainder gives sticky.
  function automatic logic [LANES*AW-1:0] ref_aln(input logic [LANES*W-1:0] a, input logic [LANES*SW-1:0] s);
    logic [LANES*AW-1:0] r;
    longint unsigned av, hi, rem;
    int sv;
    bit st;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      av = 64'(a[k*W +: W]);
      sv = int'(s[k*SW +: SW]);
      if (sv >= W) begin
        hi  = 0;
        rem = av;
      end else begin
        hi  = av / (64'd1 << sv);
        rem = av % (64'd1 << sv);
      end
      st = (rem != 0) && STK;
      r[k*AW +: AW] = {hi[W-1:0], st};
    end
    return r;
  endfunction

  typedef struct {
    logic [TAGW-1:0]     tag;
    logic [LANES*AW-1:0] aln;
  } exp_t;

  exp_t                sb[$];
  logic [TAGW-1:0]     seen[$];
  bit                  prev_hold = 1'b0;
  logic [TAGW-1:0]     prev_tag;
  logic [LANES*AW-1:0] prev_aln;

  // Monitor: samples on the falling edge, away from the edge that updates the DUT.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
        for (int k = 0; k < LANES; k++)
          chk($sformatf("hold_lane%0d", k), 64'(aln[k*AW +: AW]), 64'(prev_aln[k*AW +: AW]));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
          for (int k = 0; k < LANES; k++)
            chk($sformatf("sb_lane%0d", k), 64'(aln[k*AW +: AW]), 64'(e.aln[k*AW +: AW]));
        end
        seen.push_back(out_tag);
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_tag  = out_tag;
      prev_aln  = aln;
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.tag = in_tag;
        e.aln = ref_aln(acc, sft);
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < LANES; k++) begin
      if ($urandom_range(0, 3) == 0) acc[k*W +: W] = W'($urandom_range(0, 15));
      else                           acc[k*W +: W] = W'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0:       sft[k*SW +: SW] = SW'($urandom_range(W - 1, W + 1));
        1:       sft[k*SW +: SW] = '0;
        default: sft[k*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int next_tag;

    // Reset state.
    reset = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic shift, sft=0, and over-shift on one transaction.
    step();
    out_ready = 1'b1;
    acc = {48'h0, 48'h1, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0001};
    sft = {6'd48, 6'd63, 6'd0, 6'd1};
    in_tag = 4'h5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(STAGES));
    chk("basic_tag", 64'(out_tag), 64'h5);
    chk("basic_aln0", 64'(aln[0 +: AW]), 64'({48'h4000_0000_0000, STK}));
    chk("basic_aln1", 64'(aln[AW +: AW]), 64'({48'hFFFF_FFFF_FFFF, 1'b0}));
    chk("ovr_aln2", 64'(aln[2*AW +: AW]), 64'({48'h0, STK}));
    chk("ovr_aln3", 64'(aln[3*AW +: AW]), 64'd0);
    step();
    chk("basic_single", 64'(out_valid), 64'd0);

    // Backpressure: tags 0..7 back-to-back, out_ready low in cycles 3..8.
    seen.delete();
    next_tag = 0;
    for (int c = 0; c < 60 && seen.size() < 8; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      in_valid = (next_tag < 8);
      in_tag = TAGW'(next_tag);
      rand_data();
      @(negedge clk);
      if (c >= 3 && c <= 8) chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) next_tag++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(seen[i]), 64'(i));

    // Bubble collapse: inputs in cycles 0 and 2, out_ready low until cycle 6.
    seen.delete();
    for (int c = 0; c < 40 && seen.size() < 2; c++) begin
      out_ready = (c >= 6);
      in_valid = (c == 0 || c == 2);
      in_tag = (c == 0) ? 4'hA : 4'hB;
      rand_data();
      @(negedge clk);
      if (c == 3) begin
        chk("bub_in_ready", 64'(in_ready), 64'd0);
        chk("bub_out_valid", 64'(out_valid), 64'd1);
      end
      step();
    end
    in_valid = 1'b0;
    chk("bub_count", 64'(seen.size()), 64'd2);
    if (seen.size() >= 2) begin
      chk("bub_first", 64'(seen[0]), 64'hA);
      chk("bub_second", 64'(seen[1]), 64'hB);
    end

    // Flush with two entries in flight; the input offered in the flush cycle must be dropped.
    seen.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      in_valid = 1'b1;
      in_tag = TAGW'(i);
      rand_data();
      step();
    end
    flush = 1'b1;
    in_tag = 4'h3;
    @(negedge clk);
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("fl_no_stale", 64'(seen.size()), 64'd0);

    // Same scenario, using reset for one cycle instead of flush.
    out_ready = 1'b0;
    for (int i = 4; i <= 5; i++) begin
      in_valid = 1'b1;
      in_tag = TAGW'(i);
      rand_data();
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) step();
    chk("rs_no_stale", 64'(seen.size()), 64'd0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      in_tag = TAGW'($urandom());
      rand_data();
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
